// File: rtl/mcu_n_if.sv
// Control bus between the button/player side and the mcu_n sequencer.
//   play_pause, next, prev, song_done : one-cycle event pulses into the sequencer
//   mode                               : play mode, sampled when an event is processed
//   play, reset_play, song             : registered sequencer outputs
// master = event source / observer, slave = sequencer.
interface mcu_n_if #(
  parameter int unsigned SONG_BITS = 2
);
  logic                 play_pause;
  logic                 next;
  logic                 prev;
  logic [1:0]           mode;
  logic                 song_done;
  logic                 play;
  logic                 reset_play;
  logic [SONG_BITS-1:0] song;

  modport master (
    output play_pause, next, prev, mode, song_done,
    input  play, reset_play, song
  );

  modport slave (
    input  play_pause, next, prev, mode, song_done,
    output play, reset_play, song
  );
endinterface

// File: rtl/mcu_n.sv
// Playback sequencer over SONGS tracks with sequential, repeat-one, play-once
// and LFSR shuffle modes.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : mcu_n_if.slave (event pulses + mode in; play, reset_play, song out)
module mcu_n #(
  parameter int unsigned SONGS     = 4,
  parameter int unsigned SONG_BITS = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic   clk,
  input  logic   reset,
  mcu_n_if.slave bus
);

  // One extra bit so SONGS itself is representable when SONGS == 2^SONG_BITS.
  localparam int unsigned        SW      = SONG_BITS + 1;
  localparam logic [SW-1:0]      SONGS_W = SW'(SONGS);
  localparam logic [SW-1:0]      LAST_W  = SW'(SONGS - 1);
  localparam logic [7:0]         SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic {PAUSE = 1'b0, PLAY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 rp_q, rp_d;
  logic [7:0]           lfsr_q, lfsr_d;

  logic [SW-1:0]        song_w, r_raw, r_fold;
  logic [SONG_BITS-1:0] song_inc, song_dec, shuf_idx;
  logic                 lfsr_fb;

  // Track index arithmetic: wrap-around neighbours and shuffle pick.
  always_comb begin
    song_w   = SW'(song_q);
    song_inc = (song_w == LAST_W) ? '0 : SONG_BITS'(song_w + SW'(1));
    song_dec = (song_q == '0) ? SONG_BITS'(LAST_W) : song_q - SONG_BITS'(1);
    r_raw    = SW'(lfsr_q[SONG_BITS-1:0]);
    // A single fold suffices because SONGS > 2^(SONG_BITS-1).
    r_fold   = (r_raw >= SONGS_W) ? r_raw - SONGS_W : r_raw;
    // Never pick the current track, so shuffle always changes song.
    shuf_idx = (r_fold == song_w) ? song_inc : SONG_BITS'(r_fold);
  end

  // x^8+x^6+x^5+x^4+1 Fibonacci feedback into bit 0.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Next state: one event per cycle, next > prev > song_done > play_pause.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    rp_d    = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_fb};

    if (bus.next) begin
      song_d = (bus.mode == 2'b11) ? shuf_idx : song_inc;
      rp_d   = 1'b1;
    end else if (bus.prev) begin
      song_d = song_dec;
      rp_d   = 1'b1;
    end else if (bus.song_done && state_q == PLAY) begin
      rp_d = 1'b1;
      case (bus.mode)
        2'b00: song_d = song_inc;
        2'b01: song_d = song_q;
        2'b10: begin
          if (song_w == LAST_W) begin
            song_d  = '0;
            state_d = PAUSE;
          end else begin
            song_d = song_inc;
          end
        end
        default: song_d = shuf_idx;
      endcase
    end else if (bus.play_pause) begin
      state_d = (state_q == PLAY) ? PAUSE : PLAY;
    end
  end

  // State, index, pulse and LFSR registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PAUSE;
      song_q  <= '0;
      rp_q    <= 1'b1;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      rp_q    <= rp_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.play       = (state_q == PLAY);
  assign bus.reset_play = rp_q;
  assign bus.song       = song_q;

endmodule

// File: tb/tb_mcu_n.sv
// Scoreboard bench for mcu_n: DUT A (SONGS=4) and DUT B (SONGS=5, SONG_BITS=3).
module tb_mcu_n;

  typedef struct {
    int    cyc;
    int    song;
    bit    play;
    bit    rp;
    bit    shuf;
    int    prev;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  bit   fin_req;
  bit   mon_done;
  int   b_song;
  logic [7:0] m_lfsr;

  exp_t qa[$];
  exp_t qb[$];

  mcu_n_if #(.SONG_BITS(2)) ifa ();
  mcu_n_if #(.SONG_BITS(3)) ifb ();

  mcu_n #(.SONGS(4), .SONG_BITS(2), .LFSR_SEED(8'hA5)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa.slave)
  );

  mcu_n #(.SONGS(5), .SONG_BITS(3), .LFSR_SEED(8'hA5)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR for predicting shuffle picks.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int shuf_model(input logic [7:0] l, input int cur);
    int r;
    r = int'(l[2:0]);
    if (r >= 5) r = r - 5;
    if (r == cur) r = (cur == 4) ? 0 : cur + 1;
    return r;
  endfunction

  // Monitor: pops expectations due this cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      checks = checks + 1;
      if (int'(ifa.song) != e.song || ifa.play !== e.play || ifa.reset_play !== e.rp) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d got song=%0d play=%b rp=%b exp song=%0d play=%b rp=%b",
                 e.name, cyc, ifa.song, ifa.play, ifa.reset_play, e.song, e.play, e.rp);
      end
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      checks = checks + 1;
      if (int'(ifb.song) != e.song || ifb.play !== e.play || ifb.reset_play !== e.rp) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d got song=%0d play=%b rp=%b exp song=%0d play=%b rp=%b",
                 e.name, cyc, ifb.song, ifb.play, ifb.reset_play, e.song, e.play, e.rp);
      end
      if (e.shuf) begin
        checks = checks + 1;
        if (int'(ifb.song) == e.prev) begin
          errors = errors + 1;
          $display("FAIL shuffle_repeat cyc=%0d got song=%0d equal to previous %0d",
                   cyc, ifb.song, e.prev);
        end
      end
    end
    if (cyc >= 3) begin
      checks = checks + 1;
      if (int'(ifb.song) > 4) begin
        errors = errors + 1;
        $display("FAIL song_range cyc=%0d got song=%0d exp <= 4", cyc, ifb.song);
      end
    end
    if (fin_req && !mon_done) begin
      checks = checks + 1;
      if (qa.size() + qb.size() != 0) begin
        errors = errors + 1;
        $display("FAIL unchecked_entries got %0d exp 0", qa.size() + qb.size());
      end
      mon_done = 1'b1;
    end
  end

  // Issue one event at the current negedge and queue its expected outcome.
  task automatic ev(input bit sel, input bit pp, input bit nx, input bit pv, input bit sd,
                    input logic [1:0] md, input int es, input bit ep, input bit erp,
                    input string nm, input bit sh = 1'b0);
    exp_t e;
    e.cyc  = cyc + 1;
    e.song = es;
    e.play = ep;
    e.rp   = erp;
    e.shuf = sh;
    e.prev = b_song;
    e.name = nm;
    if (sel) begin
      qb.push_back(e);
      b_song = es;
      ifb.play_pause = pp; ifb.next = nx; ifb.prev = pv; ifb.song_done = sd; ifb.mode = md;
    end else begin
      qa.push_back(e);
      ifa.play_pause = pp; ifa.next = nx; ifa.prev = pv; ifa.song_done = sd; ifa.mode = md;
    end
    @(negedge clk);
    ifa.play_pause = 1'b0; ifa.next = 1'b0; ifa.prev = 1'b0; ifa.song_done = 1'b0;
    ifb.play_pause = 1'b0; ifb.next = 1'b0; ifb.prev = 1'b0; ifb.song_done = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   es;
    cyc = 0; errors = 0; checks = 0; fin_req = 1'b0; mon_done = 1'b0; b_song = 0;
    rst = 1'b1;
    ifa.play_pause = 1'b0; ifa.next = 1'b0; ifa.prev = 1'b0; ifa.song_done = 1'b0; ifa.mode = 2'b00;
    ifb.play_pause = 1'b0; ifb.next = 1'b0; ifb.prev = 1'b0; ifb.song_done = 1'b0; ifb.mode = 2'b00;

    // Reset held two edges, reset_play drops on the first edge after release.
    e = '{cyc: 2, song: 0, play: 1'b0, rp: 1'b1, shuf: 1'b0, prev: 0, name: "reset_a"};
    qa.push_back(e);
    e.cyc = 3; e.rp = 1'b0; e.name = "reset_release_a";
    qa.push_back(e);
    e = '{cyc: 2, song: 0, play: 1'b0, rp: 1'b1, shuf: 1'b0, prev: 0, name: "reset_b"};
    qb.push_back(e);
    e.cyc = 3; e.rp = 1'b0; e.name = "reset_release_b";
    qb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // DUT A: sequential next with wrap.
    ev(0, 1, 0, 0, 0, 2'b00, 0, 1, 0, "a_play");
    for (int i = 0; i < 4; i++) ev(0, 0, 1, 0, 0, 2'b00, (i + 1) % 4, 1, 1, "a_next");
    ev(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, "a_idle");

    // DUT B: SONGS=5 directed vectors.
    ev(1, 0, 0, 1, 0, 2'b00, 4, 0, 1, "b_prev_wrap");
    ev(1, 1, 0, 0, 0, 2'b00, 4, 1, 0, "b_play");
    ev(1, 0, 0, 0, 1, 2'b00, 0, 1, 1, "b_done_seq_wrap");
    ev(1, 0, 0, 0, 0, 2'b00, 0, 1, 0, "b_idle1");
    ev(1, 0, 0, 1, 0, 2'b10, 4, 1, 1, "b_prev_to_last");
    ev(1, 0, 0, 0, 1, 2'b10, 0, 0, 1, "b_once_last");
    ev(1, 0, 0, 0, 1, 2'b10, 0, 0, 0, "b_done_in_pause");
    ev(1, 1, 0, 0, 0, 2'b10, 0, 1, 0, "b_play2");
    ev(1, 0, 0, 0, 1, 2'b10, 1, 1, 1, "b_once_mid");
    ev(1, 0, 1, 0, 0, 2'b00, 2, 1, 1, "b_next_to_2");
    for (int i = 0; i < 3; i++) ev(1, 0, 0, 0, 1, 2'b01, 2, 1, 1, "b_repeat_one");
    ev(1, 0, 1, 0, 0, 2'b01, 3, 1, 1, "b_next_rep_mode");
    ev(1, 0, 0, 0, 0, 2'b00, 3, 1, 0, "b_idle2");
    ev(1, 1, 0, 0, 0, 2'b00, 3, 0, 0, "b_pause");
    ev(1, 0, 1, 0, 0, 2'b00, 4, 0, 1, "b_next_paused");
    ev(1, 1, 1, 1, 0, 2'b00, 0, 0, 1, "b_prio_next");
    ev(1, 1, 0, 1, 1, 2'b00, 4, 0, 1, "b_prio_prev");
    ev(1, 1, 0, 0, 0, 2'b00, 4, 1, 0, "b_play3");

    // Shuffle: back-to-back song_done pulses.
    for (int i = 0; i < 200; i++) begin
      es = shuf_model(m_lfsr, b_song);
      ev(1, 0, 0, 0, 1, 2'b11, es, 1, 1, "b_shuffle_done", 1'b1);
    end
    es = shuf_model(m_lfsr, b_song);
    ev(1, 1, 1, 1, 1, 2'b11, es, 1, 1, "b_prio_shuffle_next", 1'b1);
    ev(1, 0, 0, 0, 0, 2'b11, b_song, 1, 0, "b_idle3");

    @(negedge clk);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
    if (!mon_done) $display("FAIL monitor_done got 0 exp 1");
    $display("Result: errors=%0d of %0d checks", errors + (mon_done ? 0 : 1), checks);
    $finish;
  end

endmodule
